// File: rtl/pkt_builder_pkg.sv
// Shared definitions for the packet builder: protocol numbers, header length
// constants, record layouts, FSM states and the IPv4 header checksum helper.
// Contents:
//   five_tuple_t / pkt_info_t : field layout of the incoming record
//   state_t                   : IDLE -> CSUM -> SEND
//   ipv4_csum()               : one's-complement checksum over a 20-byte header
package pkt_builder_pkg;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  PROTO_TCP     = 8'd6;
    localparam logic [7:0]  PROTO_UDP     = 8'd17;

    localparam logic [15:0] ETH_HDR_LEN   = 16'd14;
    localparam logic [15:0] TCP_HDR_MIN   = 16'd40;  // IPv4 + TCP headers
    localparam logic [15:0] UDP_HDR_MIN   = 16'd28;  // IPv4 + UDP headers
    localparam logic [15:0] MIN_FRAME_LEN = 16'd60;

    localparam int HDR_BYTES  = 56;  // header bytes held for beats 0..6
    localparam int IP_HDR_OFF = 14;  // first IPv4 header byte in the frame

    typedef struct packed {
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [7:0]  protocol;
    } five_tuple_t;

    typedef struct packed {
        logic [7:0]  tcp_flags;
        logic [31:0] timestamp;
        logic [15:0] ip_total_length;
    } pkt_info_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CSUM = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    // Byte j of the header sits at hdr[j*8 +: 8]; words are big-endian byte pairs.
    function automatic logic [15:0] ipv4_csum(input logic [159:0] hdr);
        logic [19:0] acc;
        logic [16:0] fold1;
        logic [15:0] fold2;
        acc = 20'd0;
        for (int i = 0; i < 10; i++) begin
            acc = acc + {4'd0, hdr[i*16 +: 8], hdr[i*16 + 8 +: 8]};
        end
        fold1 = {1'b0, acc[15:0]} + {13'd0, acc[19:16]};
        fold2 = fold1[15:0] + {15'd0, fold1[16]};
        return ~fold2;
    endfunction

endpackage

// File: rtl/pkt_builder_csum.sv
// Combinational IPv4 header checksum.
// Ports:
//   i_ip_hdr [159:0] : 20 header bytes, byte 0 in [7:0], checksum field zero
//   o_csum   [15:0]  : inverted, twice-folded one's-complement sum
module pkt_builder_csum
    import pkt_builder_pkg::*;
(
    input  logic [159:0] i_ip_hdr,
    output logic [15:0]  o_csum
);

    assign o_csum = ipv4_csum(i_ip_hdr);

endmodule

// File: rtl/pkt_builder.sv
// Builds an untagged Ethernet/IPv4/TCP|UDP frame from one {five_tuple, pkt_info}
// record and streams it on a 64-bit AXI-Stream master, byte 0 on TDATA[7:0].
// Ports:
//   ACLK, ARESET            : clock, synchronous active-high reset
//   five_tuple, pkt_info    : record, qualified by tuple_and_info_valid
//   tuple_ready             : high only while idle
//   M_AXIS_*                : frame stream (registered outputs)
//   num_sent_pkts           : frames completed with a TLAST handshake
//   num_dropped_pkts        : records discarded (bad protocol or busy)
module pkt_builder
    import pkt_builder_pkg::*;
#(
    parameter logic [47:0] DST_MAC    = 48'h020000000002,
    parameter logic [47:0] SRC_MAC    = 48'h020000000001,
    parameter logic [7:0]  IP_TTL     = 8'd64,
    parameter logic [15:0] MAX_IP_LEN = 16'd1500
) (
    input  logic         ACLK,
    input  logic         ARESET,
    input  logic [103:0] five_tuple,
    input  logic [55:0]  pkt_info,
    input  logic         tuple_and_info_valid,
    output logic         tuple_ready,
    output logic [63:0]  M_AXIS_TDATA,
    output logic [7:0]   M_AXIS_TSTRB,
    output logic         M_AXIS_TVALID,
    output logic         M_AXIS_TLAST,
    input  logic         M_AXIS_TREADY,
    output logic [31:0]  num_sent_pkts,
    output logic [31:0]  num_dropped_pkts
);

    state_t        r_state, w_next_state;
    five_tuple_t   r_tuple, w_in_tuple;
    pkt_info_t     w_in_info;
    logic [7:0]    r_flags;
    logic [15:0]   r_len;
    logic [15:0]   r_ip_id;
    logic [447:0]  r_hdr;
    logic [7:0]    r_beats, r_last_strb, r_beat;
    logic          r_tvalid, r_tlast, r_ready;
    logic [63:0]   r_tdata;
    logic [7:0]    r_tstrb;
    logic [31:0]   r_sent, r_dropped;

    logic          w_accept, w_drop, w_handshake, w_last_hs, w_is_tcp, w_unused_ts;
    logic [15:0]   w_hdr_min, w_ip_len, w_frame_len, w_udp_len, w_csum;
    logic [7:0]    w_beats, w_last_strb, w_beat_nxt;
    logic [63:0]   w_beat_data;
    logic [7:0]    w_bytes [HDR_BYTES];
    logic [447:0]  w_hdr_base, w_hdr;

    assign w_in_tuple  = five_tuple;
    assign w_in_info   = pkt_info;
    assign w_unused_ts = ^w_in_info.timestamp;

    assign w_accept    = tuple_and_info_valid && (r_state == ST_IDLE) &&
                         ((w_in_tuple.protocol == PROTO_TCP) || (w_in_tuple.protocol == PROTO_UDP));
    assign w_drop      = tuple_and_info_valid && !w_accept;
    assign w_handshake = r_tvalid && M_AXIS_TREADY;
    assign w_last_hs   = w_handshake && r_tlast;

    // FSM state register.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_CSUM;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_CSUM: w_next_state = ST_SEND;
            ST_SEND: begin
                if (w_last_hs) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_SEND;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Record latch; only the fields the frame needs are kept.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_tuple <= '{default: '0};
            r_flags <= 8'd0;
            r_len   <= 16'd0;
        end else if (w_accept) begin
            r_tuple <= w_in_tuple;
            r_flags <= w_in_info.tcp_flags;
            r_len   <= w_in_info.ip_total_length;
        end
    end

    // Length clamping, frame size, beat count and last-beat byte enables.
    always_comb begin
        w_is_tcp  = (r_tuple.protocol == PROTO_TCP);
        w_hdr_min = w_is_tcp ? TCP_HDR_MIN : UDP_HDR_MIN;
        if (r_len < w_hdr_min) begin
            w_ip_len = w_hdr_min;
        end else if (r_len > MAX_IP_LEN) begin
            w_ip_len = MAX_IP_LEN;
        end else begin
            w_ip_len = r_len;
        end
        w_udp_len = w_ip_len - 16'd20;
        if ((ETH_HDR_LEN + w_ip_len) < MIN_FRAME_LEN) begin
            w_frame_len = MIN_FRAME_LEN;
        end else begin
            w_frame_len = ETH_HDR_LEN + w_ip_len;
        end
        w_beats = 8'((w_frame_len + 16'd7) >> 3);
        if (w_frame_len[2:0] == 3'd0) begin
            w_last_strb = 8'hFF;
        end else begin
            w_last_strb = (8'd1 << w_frame_len[2:0]) - 8'd1;
        end
    end

    // Header bytes in wire order; the checksum bytes are filled in afterwards.
    always_comb begin
        for (int k = 0; k < HDR_BYTES; k++) begin
            w_bytes[k] = 8'd0;
        end
        for (int k = 0; k < 6; k++) begin
            w_bytes[k]     = DST_MAC[(5 - k)*8 +: 8];
            w_bytes[k + 6] = SRC_MAC[(5 - k)*8 +: 8];
        end
        w_bytes[12] = ETH_TYPE_IPV4[15:8];
        w_bytes[13] = ETH_TYPE_IPV4[7:0];
        w_bytes[14] = 8'h45;
        w_bytes[16] = w_ip_len[15:8];
        w_bytes[17] = w_ip_len[7:0];
        w_bytes[18] = r_ip_id[15:8];
        w_bytes[19] = r_ip_id[7:0];
        w_bytes[20] = 8'h40;
        w_bytes[22] = IP_TTL;
        w_bytes[23] = r_tuple.protocol;
        for (int k = 0; k < 4; k++) begin
            w_bytes[26 + k] = r_tuple.src_ip[(3 - k)*8 +: 8];
            w_bytes[30 + k] = r_tuple.dst_ip[(3 - k)*8 +: 8];
        end
        w_bytes[34] = r_tuple.src_port[15:8];
        w_bytes[35] = r_tuple.src_port[7:0];
        w_bytes[36] = r_tuple.dst_port[15:8];
        w_bytes[37] = r_tuple.dst_port[7:0];
        if (w_is_tcp) begin
            w_bytes[46] = 8'h50;
            w_bytes[47] = r_flags;
            w_bytes[48] = 8'hFF;
            w_bytes[49] = 8'hFF;
        end else begin
            w_bytes[38] = w_udp_len[15:8];
            w_bytes[39] = w_udp_len[7:0];
        end
    end

    // Pack header bytes, byte k in bits [k*8 +: 8].
    always_comb begin
        w_hdr_base = 448'd0;
        for (int k = 0; k < HDR_BYTES; k++) begin
            w_hdr_base[k*8 +: 8] = w_bytes[k];
        end
    end

    pkt_builder_csum u_csum (
        .i_ip_hdr (w_hdr_base[IP_HDR_OFF*8 +: 160]),
        .o_csum   (w_csum)
    );

    // Insert the checksum into bytes 24-25.
    always_comb begin
        w_hdr            = w_hdr_base;
        w_hdr[24*8 +: 8] = w_csum[15:8];
        w_hdr[25*8 +: 8] = w_csum[7:0];
    end

    // Next beat data: header words for beats 0..6, zero pad afterwards.
    always_comb begin
        w_beat_nxt = r_beat + 8'd1;
        if (w_beat_nxt < 8'd7) begin
            w_beat_data = r_hdr[{w_beat_nxt[2:0], 6'd0} +: 64];
        end else begin
            w_beat_data = 64'd0;
        end
    end

    // Beat registers: beat 0 loads in CSUM, later beats load on each handshake.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_hdr       <= 448'd0;
            r_beats     <= 8'd0;
            r_last_strb <= 8'd0;
            r_beat      <= 8'd0;
            r_tvalid    <= 1'b0;
            r_tdata     <= 64'd0;
            r_tstrb     <= 8'd0;
            r_tlast     <= 1'b0;
        end else begin
            case (r_state)
                ST_CSUM: begin
                    r_hdr       <= w_hdr;
                    r_beats     <= w_beats;
                    r_last_strb <= w_last_strb;
                    r_beat      <= 8'd0;
                    r_tvalid    <= 1'b1;
                    r_tdata     <= w_hdr[63:0];
                    r_tstrb     <= 8'hFF;
                    r_tlast     <= 1'b0;  // every frame is at least 8 beats
                end
                ST_SEND: begin
                    if (w_handshake) begin
                        if (r_tlast) begin
                            r_tvalid <= 1'b0;
                            r_tdata  <= 64'd0;
                            r_tstrb  <= 8'd0;
                            r_tlast  <= 1'b0;
                        end else begin
                            r_beat  <= w_beat_nxt;
                            r_tdata <= w_beat_data;
                            r_tlast <= (w_beat_nxt == (r_beats - 8'd1));
                            r_tstrb <= (w_beat_nxt == (r_beats - 8'd1)) ? r_last_strb : 8'hFF;
                        end
                    end
                end
                default: begin
                    r_tvalid <= 1'b0;
                end
            endcase
        end
    end

    // Frame / drop counters and the IPv4 identification field.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_sent    <= 32'd0;
            r_dropped <= 32'd0;
            r_ip_id   <= 16'd0;
        end else begin
            if (w_drop) begin
                r_dropped <= r_dropped + 32'd1;
            end
            if (w_last_hs) begin
                r_sent  <= r_sent + 32'd1;
                r_ip_id <= r_ip_id + 16'd1;
            end
        end
    end

    // Registered ready: mirrors the state the FSM is entering.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_ready <= 1'b1;
        end else begin
            r_ready <= (w_next_state == ST_IDLE);
        end
    end

    assign tuple_ready      = r_ready;
    assign M_AXIS_TDATA     = r_tdata;
    assign M_AXIS_TSTRB     = r_tstrb;
    assign M_AXIS_TVALID    = r_tvalid;
    assign M_AXIS_TLAST     = r_tlast;
    assign num_sent_pkts    = r_sent;
    assign num_dropped_pkts = r_dropped;

endmodule

// File: tb/tb_pkt_builder.sv
// Self-checking bench for pkt_builder: a table of directed records, hand-written
// drop and reset sequences, and randomized records with random back-pressure.
// Expected frames come from a byte-level reference model built from the frame
// format rules.
module tb_pkt_builder;

    logic         clk = 1'b0;
    logic         ARESET;
    logic [103:0] five_tuple;
    logic [55:0]  pkt_info;
    logic         tuple_and_info_valid;
    logic         tuple_ready;
    logic [63:0]  M_AXIS_TDATA;
    logic [7:0]   M_AXIS_TSTRB;
    logic         M_AXIS_TVALID;
    logic         M_AXIS_TLAST;
    logic         M_AXIS_TREADY;
    logic [31:0]  num_sent_pkts;
    logic [31:0]  num_dropped_pkts;

    always #5 clk = ~clk;

    pkt_builder dut (
        .ACLK                 (clk),
        .ARESET               (ARESET),
        .five_tuple           (five_tuple),
        .pkt_info             (pkt_info),
        .tuple_and_info_valid (tuple_and_info_valid),
        .tuple_ready          (tuple_ready),
        .M_AXIS_TDATA         (M_AXIS_TDATA),
        .M_AXIS_TSTRB         (M_AXIS_TSTRB),
        .M_AXIS_TVALID        (M_AXIS_TVALID),
        .M_AXIS_TLAST         (M_AXIS_TLAST),
        .M_AXIS_TREADY        (M_AXIS_TREADY),
        .num_sent_pkts        (num_sent_pkts),
        .num_dropped_pkts     (num_dropped_pkts)
    );

    typedef struct {
        logic [7:0]  proto;
        logic [7:0]  flags;
        logic [15:0] len_in;
        int          stall;
        int          exp_beats;
        logic [7:0]  exp_strb;
        logic [15:0] exp_iplen;
    } vec_t;

    vec_t        vt [10];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [7:0]  exp_b [0:2047];
    int          exp_len;
    logic [7:0]  rx_b  [0:2047];
    int          rx_len;
    logic [15:0] exp_id;
    logic [31:0] exp_sent, exp_dropped;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference frame built byte by byte from the frame format rules.
    task automatic model_frame(input logic [103:0] t, input logic [55:0] inf, input logic [15:0] id);
        int iplen, flen, minlen, sum;
        logic [7:0]  proto;
        logic [47:0] dmac, smac;
        dmac   = 48'h020000000002;
        smac   = 48'h020000000001;
        proto  = t[7:0];
        minlen = (proto == 8'd6) ? 40 : 28;
        iplen  = int'(inf[15:0]);
        if (iplen < minlen) iplen = minlen;
        if (iplen > 1500) iplen = 1500;
        flen = 14 + iplen;
        if (flen < 60) flen = 60;
        for (int i = 0; i < flen; i++) exp_b[i] = 8'd0;
        for (int i = 0; i < 6; i++) begin
            exp_b[i]     = dmac[47 - 8*i -: 8];
            exp_b[6 + i] = smac[47 - 8*i -: 8];
        end
        exp_b[12] = 8'h08;
        exp_b[14] = 8'h45;
        exp_b[16] = 8'(iplen / 256);
        exp_b[17] = 8'(iplen % 256);
        exp_b[18] = id[15:8];
        exp_b[19] = id[7:0];
        exp_b[20] = 8'h40;
        exp_b[22] = 8'd64;
        exp_b[23] = proto;
        for (int i = 0; i < 4; i++) begin
            exp_b[26 + i] = t[103 - 8*i -: 8];
            exp_b[30 + i] = t[71 - 8*i -: 8];
        end
        exp_b[34] = t[39:32];
        exp_b[35] = t[31:24];
        exp_b[36] = t[23:16];
        exp_b[37] = t[15:8];
        if (proto == 8'd6) begin
            exp_b[46] = 8'h50;
            exp_b[47] = inf[55:48];
            exp_b[48] = 8'hFF;
            exp_b[49] = 8'hFF;
        end else begin
            exp_b[38] = 8'((iplen - 20) / 256);
            exp_b[39] = 8'((iplen - 20) % 256);
        end
        sum = 0;
        for (int w = 0; w < 10; w++) sum += int'(exp_b[14 + 2*w]) * 256 + int'(exp_b[15 + 2*w]);
        while (sum > 65535) sum = (sum % 65536) + (sum / 65536);
        sum = 65535 - sum;
        exp_b[24] = 8'(sum / 256);
        exp_b[25] = 8'(sum % 256);
        exp_len = flen;
    endtask

    task automatic compare_frame(input string name);
        int first_bad, n, sum;
        first_bad = -1;
        check({name, "_len"}, 64'(rx_len), 64'(exp_len));
        n = (rx_len < exp_len) ? rx_len : exp_len;
        for (int i = 0; i < n; i++) begin
            if (rx_b[i] !== exp_b[i] && first_bad < 0) first_bad = i;
        end
        n_vec++;
        if (first_bad >= 0) begin
            n_bad++;
            $display("FAIL %s_bytes: byte %0d got %02h, expected %02h", name, first_bad,
                     rx_b[first_bad], exp_b[first_bad]);
        end
        sum = 0;
        if (rx_len >= 34) begin
            for (int w = 0; w < 10; w++) sum += int'(rx_b[14 + 2*w]) * 256 + int'(rx_b[15 + 2*w]);
            while (sum > 65535) sum = (sum % 65536) + (sum / 65536);
        end
        check({name, "_hdr_sum"}, 64'(sum), 64'h0000_0000_0000_FFFF);
    endtask

    // Present one record; check the accept/drop response and first-beat latency.
    task automatic start_record(input logic [103:0] t, input logic [55:0] inf, input bit accept);
        five_tuple           = t;
        pkt_info             = inf;
        tuple_and_info_valid = 1'b1;
        tick();
        tuple_and_info_valid = 1'b0;
        if (accept) begin
            check("lat_n1_tvalid", 64'(M_AXIS_TVALID), 64'd0);
            check("busy_ready", 64'(tuple_ready), 64'd0);
            tick();
            check("lat_n2_tvalid", 64'(M_AXIS_TVALID), 64'd1);
        end else begin
            exp_dropped++;
            check("drop_ready", 64'(tuple_ready), 64'd1);
            check("drop_count", 64'(num_dropped_pkts), 64'(exp_dropped));
            tick();
            check("drop_no_tvalid", 64'(M_AXIS_TVALID), 64'd0);
        end
    endtask

    // Sink one frame with optional stalls, a mid-frame strobe, or a reset at a beat.
    task automatic recv_frame(input int stall_pct, input int inject_beat, input int abort_beat,
                              output int nbeats, output logic [7:0] last_strb, output bit got_last);
        bit          done, hold, stable_ok, strb_ok, injected;
        logic [63:0] h_data;
        logic [7:0]  h_strb;
        logic        h_last;
        int          cycles;
        nbeats = 0; last_strb = 8'd0; got_last = 1'b0; done = 1'b0; hold = 1'b0;
        stable_ok = 1'b1; strb_ok = 1'b1; injected = 1'b0; cycles = 0; rx_len = 0;
        h_data = 64'd0; h_strb = 8'd0; h_last = 1'b0;
        while (!done && cycles < 4000) begin
            if (hold) begin
                if (M_AXIS_TVALID !== 1'b1 || M_AXIS_TDATA !== h_data ||
                    M_AXIS_TSTRB !== h_strb || M_AXIS_TLAST !== h_last) stable_ok = 1'b0;
            end
            M_AXIS_TREADY = (stall_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= stall_pct);
            hold = 1'b0;
            if (M_AXIS_TVALID === 1'b1) begin
                if (M_AXIS_TREADY) begin
                    for (int b = 0; b < 8; b++) begin
                        if (M_AXIS_TSTRB[b] && rx_len < 2048) begin
                            rx_b[rx_len] = M_AXIS_TDATA[8*b +: 8];
                            rx_len++;
                        end
                    end
                    if (!M_AXIS_TLAST && M_AXIS_TSTRB !== 8'hFF) strb_ok = 1'b0;
                    nbeats++;
                    if (M_AXIS_TLAST) begin
                        last_strb = M_AXIS_TSTRB;
                        got_last  = 1'b1;
                        done      = 1'b1;
                    end
                end else begin
                    hold   = 1'b1;
                    h_data = M_AXIS_TDATA;
                    h_strb = M_AXIS_TSTRB;
                    h_last = M_AXIS_TLAST;
                end
            end
            if (inject_beat >= 0 && !injected && nbeats == inject_beat) begin
                five_tuple           = {32'h0B0B0B0B, 32'h0C0C0C0C, 16'd7, 16'd9, 8'd6};
                pkt_info             = {8'h02, 32'd0, 16'd100};
                tuple_and_info_valid = 1'b1;
                injected             = 1'b1;
            end
            if (abort_beat >= 0 && nbeats == abort_beat) begin
                ARESET = 1'b1;
                done   = 1'b1;
            end
            tick();
            tuple_and_info_valid = 1'b0;
            cycles++;
        end
        if (abort_beat < 0) begin
            check("stall_stable", 64'(stable_ok), 64'd1);
            check("nonlast_tstrb", 64'(strb_ok), 64'd1);
        end
        if (!done) begin
            n_vec++;
            n_bad++;
            $display("FAIL recv_timeout: got %0d beats, required a TLAST within 4000 cycles", nbeats);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          nb;
        logic [7:0]  ls;
        bit          gl;
        bit          extra;
        logic [103:0] t;
        logic [55:0]  inf;
        logic [7:0]   pr;
        int           st;

        //            proto  flags  len_in  stall beats strb   iplen
        vt[0] = '{8'd17, 8'h00, 16'd28,   0,  8,   8'h0F, 16'd28};
        vt[1] = '{8'd6,  8'h12, 16'd1000, 0,  127, 8'h3F, 16'd1000};
        vt[2] = '{8'd6,  8'h18, 16'd9000, 0,  190, 8'h03, 16'd1500};
        vt[3] = '{8'd17, 8'h00, 16'd10,   0,  8,   8'h0F, 16'd28};
        vt[4] = '{8'd17, 8'h00, 16'd28,   50, 8,   8'h0F, 16'd28};
        vt[5] = '{8'd6,  8'h02, 16'd0,    0,  8,   8'h0F, 16'd40};
        vt[6] = '{8'd17, 8'h00, 16'd47,   30, 8,   8'h1F, 16'd47};
        vt[7] = '{8'd6,  8'h10, 16'd50,   0,  8,   8'hFF, 16'd50};
        vt[8] = '{8'd17, 8'h00, 16'd1501, 40, 190, 8'h03, 16'd1500};
        vt[9] = '{8'd6,  8'h11, 16'd1499, 0,  190, 8'h01, 16'd1499};

        ARESET = 1'b1; five_tuple = 104'd0; pkt_info = 56'd0;
        tuple_and_info_valid = 1'b0; M_AXIS_TREADY = 1'b1;
        tick(); tick(); tick();
        ARESET = 1'b0;
        check("rst_tvalid", 64'(M_AXIS_TVALID), 64'd0);
        check("rst_tdata", M_AXIS_TDATA, 64'd0);
        check("rst_tstrb_tlast", 64'({M_AXIS_TSTRB, M_AXIS_TLAST}), 64'd0);
        check("rst_ready", 64'(tuple_ready), 64'd1);
        check("rst_counters", {num_sent_pkts, num_dropped_pkts}, 64'd0);
        exp_id = 16'd0; exp_sent = 32'd0; exp_dropped = 32'd0;

        for (int i = 0; i < 10; i++) begin
            t   = {32'hC0A80001 + 32'(i), 32'h0A000001, 16'(1000 + i), 16'd80, vt[i].proto};
            inf = {vt[i].flags, 32'h12345678, vt[i].len_in};
            model_frame(t, inf, exp_id);
            start_record(t, inf, 1'b1);
            recv_frame(vt[i].stall, -1, -1, nb, ls, gl);
            check($sformatf("v%0d_beats", i), 64'(nb), 64'(vt[i].exp_beats));
            check($sformatf("v%0d_last_strb", i), 64'(ls), 64'(vt[i].exp_strb));
            check($sformatf("v%0d_tlast", i), 64'(gl), 64'd1);
            check($sformatf("v%0d_iplen", i), 64'({rx_b[16], rx_b[17]}), 64'(vt[i].exp_iplen));
            compare_frame($sformatf("v%0d", i));
            exp_id++; exp_sent++;
            check($sformatf("v%0d_sent", i), 64'(num_sent_pkts), 64'(exp_sent));
        end

        // Unsupported protocol, then a strobe while a frame is in flight.
        start_record({32'h01020304, 32'h05060708, 16'd1, 16'd2, 8'h01}, {8'h00, 32'd0, 16'd64}, 1'b0);
        t   = {32'hAC100001, 32'hAC100002, 16'd5000, 16'd53, 8'd17};
        inf = {8'h00, 32'd0, 16'd28};
        model_frame(t, inf, exp_id);
        start_record(t, inf, 1'b1);
        recv_frame(0, 2, -1, nb, ls, gl);
        exp_dropped++; exp_id++; exp_sent++;
        check("busy_drop_count", 64'(num_dropped_pkts), 64'd2);
        compare_frame("busy_frame");
        check("busy_sent", 64'(num_sent_pkts), 64'(exp_sent));
        extra = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (M_AXIS_TVALID !== 1'b0) extra = 1'b1;
            tick();
        end
        check("busy_no_extra_frame", 64'(extra), 64'd0);

        // Reset in the middle of a frame, then a fresh record.
        start_record({32'h0A0A0A0A, 32'h0B0B0B0B, 16'd1, 16'd2, 8'd17}, {8'h00, 32'd0, 16'd200}, 1'b1);
        recv_frame(0, -1, 3, nb, ls, gl);
        ARESET = 1'b0;
        check("abort_tvalid", 64'(M_AXIS_TVALID), 64'd0);
        check("abort_tlast", 64'(M_AXIS_TLAST), 64'd0);
        check("abort_ready", 64'(tuple_ready), 64'd1);
        check("abort_counters", {num_sent_pkts, num_dropped_pkts}, 64'd0);
        exp_id = 16'd0; exp_sent = 32'd0; exp_dropped = 32'd0;
        t   = {32'hC0000201, 32'hC0000202, 16'd4242, 16'd443, 8'd6};
        inf = {8'h18, 32'd0, 16'd120};
        model_frame(t, inf, exp_id);
        start_record(t, inf, 1'b1);
        recv_frame(0, -1, -1, nb, ls, gl);
        check("post_rst_ip_id", 64'({rx_b[18], rx_b[19]}), 64'd0);
        compare_frame("post_rst");
        exp_id++; exp_sent++;
        check("post_rst_sent", 64'(num_sent_pkts), 64'd1);

        // Randomized records against the reference model.
        for (int i = 0; i < 24; i++) begin
            st = $urandom_range(0, 9);
            pr = (st == 0) ? 8'd47 : ((st < 5) ? 8'd6 : 8'd17);
            t   = {32'($urandom()), 32'($urandom()), 16'($urandom()), 16'($urandom()), pr};
            inf = {8'($urandom()), 32'($urandom()),
                   ($urandom_range(0, 9) == 0) ? 16'd9000 : 16'($urandom_range(0, 1600))};
            if (pr == 8'd47) begin
                start_record(t, inf, 1'b0);
            end else begin
                model_frame(t, inf, exp_id);
                start_record(t, inf, 1'b1);
                recv_frame(int'($urandom_range(0, 3)) * 20, -1, -1, nb, ls, gl);
                compare_frame($sformatf("rnd%0d", i));
                exp_id++; exp_sent++;
                check($sformatf("rnd%0d_sent", i), 64'(num_sent_pkts), 64'(exp_sent));
            end
            check($sformatf("rnd%0d_dropped", i), 64'(num_dropped_pkts), 64'(exp_dropped));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
